mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory bus between the instruction-fetch requester (IF stage) and the data-memory requester (MEM stage) of the 5-stage pipeline.
- Runs a three-state FSM with registered request capture and a one-cycle ready pulse per requester.
- Gives MEM-stage priority, with an anti-starvation counter for IF and a bus-timeout abort.
- Drives per-requester stall outputs that the hazard logic ORs into PC/IFID write-enable and pipeline freeze.

---
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// IF/MEM requester ports and the shared memory bus port for mem_port_arbiter.
// The arbiter takes the master view; the surrounding pipeline and bus model take the slave view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_ready;
    logic              if_stall;

    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              mem_stall;

    logic              bus_valid;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;

    logic              err;
    logic [1:0]        owner;

    modport master (
        input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, bus_rdata, bus_ack,
        output if_rdata, if_ready, if_stall, mem_rdata, mem_ready, mem_stall,
               bus_valid, bus_we, bus_addr, bus_wdata, err, owner
    );

    modport slave (
        output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, bus_rdata, bus_ack,
        input  if_rdata, if_ready, if_stall, mem_rdata, mem_ready, mem_stall,
               bus_valid, bus_we, bus_addr, bus_wdata, err, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between IF fetch and MEM data requests, MEM first with IF anti-starvation.
// Request to ready >= 2 cycles; requesters stall until their ready pulse, bus stalls via bus_ack or timeout.
module mem_port_arbiter #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.master  ap
);
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [SC_W-1:0] STARVE_TOP = SC_W'(STARVE_MAX);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYC - 1);

    // Encoding doubles as the owner output.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GNT_IF  = 2'b01,
        GNT_MEM = 2'b10
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;
    logic [SC_W-1:0]   starve_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [31:0]       if_rdata_r;
    logic [DATA_W-1:0] mem_rdata_r;
    logic              if_ready_r, mem_ready_r, err_r;

    logic mem_req, if_priority;
    logic grant_if, grant_mem, done, abort;

    assign mem_req     = ap.mem_rd | ap.mem_wr;
    assign if_priority = ap.if_req & (starve_cnt == STARVE_TOP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_req && !if_priority) begin
                    state_nxt = GNT_MEM;
                    grant_mem = 1'b1;
                end else if (ap.if_req) begin
                    state_nxt = GNT_IF;
                    grant_if  = 1'b1;
                end
            end
            GNT_IF, GNT_MEM: begin
                // A late ack on the final timeout cycle still completes normally.
                if (ap.bus_ack) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_we      <= 1'b0;
            starve_cnt  <= '0;
            to_cnt      <= '0;
            if_rdata_r  <= '0;
            mem_rdata_r <= '0;
            if_ready_r  <= 1'b0;
            mem_ready_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            if_ready_r  <= 1'b0;
            mem_ready_r <= 1'b0;
            err_r       <= 1'b0;

            if (grant_if) begin
                lat_addr   <= ap.if_addr;
                lat_wdata  <= '0;
                lat_we     <= 1'b0;
                starve_cnt <= '0;
            end
            if (grant_mem) begin
                lat_addr  <= ap.mem_addr;
                lat_wdata <= ap.mem_wdata;
                lat_we    <= ap.mem_wr;
                if (ap.if_req && starve_cnt != STARVE_TOP)
                    starve_cnt <= starve_cnt + 1'b1;
            end

            if (grant_if || grant_mem) to_cnt <= '0;
            else if (state != IDLE)    to_cnt <= to_cnt + 1'b1;

            if (done || abort) begin
                err_r <= abort;
                if (state == GNT_IF) begin
                    if_ready_r <= 1'b1;
                    if (abort)            if_rdata_r <= '0;
                    else if (lat_addr[2]) if_rdata_r <= ap.bus_rdata[32 +: 32];
                    else                  if_rdata_r <= ap.bus_rdata[0 +: 32];
                end else begin
                    mem_ready_r <= 1'b1;
                    if (abort)        mem_rdata_r <= '0;
                    else if (!lat_we) mem_rdata_r <= ap.bus_rdata;
                end
            end
        end
    end

    assign ap.bus_valid = (state != IDLE);
    assign ap.owner     = state;
    assign ap.bus_we    = lat_we;
    assign ap.bus_addr  = lat_addr;
    assign ap.bus_wdata = lat_wdata;
    assign ap.if_rdata  = if_rdata_r;
    assign ap.mem_rdata = mem_rdata_r;
    assign ap.if_ready  = if_ready_r;
    assign ap.mem_ready = mem_ready_r;
    assign ap.err       = err_r;
    assign ap.if_stall  = ap.if_req & ~if_ready_r;
    assign ap.mem_stall = mem_req & ~mem_ready_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 64, DATA_W = 64, STARVE_MAX = 4, TIMEOUT_CYC = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset(reset), .ap(bif.master)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, its age in cycles, and the starvation tally.
    int          m_owner = 0;
    int          m_age   = 0;
    int          m_starve = 0;
    logic [63:0] m_addr = '0, m_wdata = '0, m_mem_rdata = '0;
    logic [31:0] m_if_rdata = '0;
    logic        m_we = 1'b0, m_if_rdy = 1'b0, m_mem_rdy = 1'b0, m_err = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_owner = 0; m_age = 0; m_starve = 0;
            m_addr = '0; m_wdata = '0; m_we = 1'b0;
            m_if_rdata = '0; m_mem_rdata = '0;
            m_if_rdy = 1'b0; m_mem_rdy = 1'b0; m_err = 1'b0;
        end else begin
            bit tmo;
            logic [63:0] rd;
            m_if_rdy = 1'b0; m_mem_rdy = 1'b0; m_err = 1'b0;
            rd = bif.bus_rdata;
            if (m_owner == 0) begin
                if ((bif.mem_rd || bif.mem_wr) && !(bif.if_req && m_starve == STARVE_MAX)) begin
                    m_owner = 2; m_age = 1;
                    m_addr = bif.mem_addr; m_wdata = bif.mem_wdata; m_we = bif.mem_wr;
                    if (bif.if_req && m_starve < STARVE_MAX) m_starve = m_starve + 1;
                end else if (bif.if_req) begin
                    m_owner = 1; m_age = 1;
                    m_addr = bif.if_addr; m_wdata = '0; m_we = 1'b0;
                    m_starve = 0;
                end
            end else begin
                tmo = !bif.bus_ack && (m_age == TIMEOUT_CYC);
                if (bif.bus_ack || tmo) begin
                    m_err = tmo;
                    if (m_owner == 1) begin
                        m_if_rdy = 1'b1;
                        m_if_rdata = tmo ? 32'h0 : (m_addr[2] ? rd[63:32] : rd[31:0]);
                    end else begin
                        m_mem_rdy = 1'b1;
                        if (tmo)       m_mem_rdata = '0;
                        else if (!m_we) m_mem_rdata = rd;
                    end
                    m_owner = 0;
                end else begin
                    m_age = m_age + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("bus_valid", 64'(bif.bus_valid), 64'(m_owner != 0));
        chk("owner", 64'(bif.owner), 64'(m_owner));
        if (m_owner != 0) begin
            chk("bus_addr", bif.bus_addr, m_addr);
            chk("bus_we", 64'(bif.bus_we), 64'(m_we));
            chk("bus_wdata", bif.bus_wdata, m_wdata);
        end
        chk("if_ready", 64'(bif.if_ready), 64'(m_if_rdy));
        chk("mem_ready", 64'(bif.mem_ready), 64'(m_mem_rdy));
        chk("err", 64'(bif.err), 64'(m_err));
        chk("if_rdata", 64'(bif.if_rdata), 64'(m_if_rdata));
        chk("mem_rdata", bif.mem_rdata, m_mem_rdata);
        chk("if_stall", 64'(bif.if_stall), 64'(bif.if_req & ~m_if_rdy));
        chk("mem_stall", 64'(bif.mem_stall), 64'((bif.mem_rd | bif.mem_wr) & ~m_mem_rdy));
    end

    // Bus responder: acks on the (ack_delay+1)-th valid cycle; force_ack drives a stray ack.
    int vcnt = 0;
    bit ack_en = 1'b1;
    bit force_ack = 1'b0;
    int ack_delay = 0;
    always @(posedge clk) begin
        #3;
        vcnt = bif.bus_valid ? vcnt + 1 : 0;
        bif.bus_ack = force_ack || (ack_en && bif.bus_valid && vcnt == ack_delay + 1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready(input bit want_if, input int budget, output int cyc, output int vcyc);
        bit seen;
        seen = 1'b0;
        cyc = 0;
        vcyc = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            cyc++;
            if (bif.bus_valid) vcyc++;
            if (want_if ? bif.if_ready : bif.mem_ready) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_wait: no %s ready within %0d cycles", want_if ? "if" : "mem", budget);
        end
    endtask

    initial begin
        int cyc, vcyc, pulses, mem_g, if_g, run1, run2, prev;
        bit stop;
        bif.if_req = 1'b0; bif.if_addr = '0;
        bif.mem_rd = 1'b0; bif.mem_wr = 1'b0; bif.mem_addr = '0; bif.mem_wdata = '0;
        bif.bus_rdata = 64'hAAAA_BBBB_CCCC_DDDD; bif.bus_ack = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_bus_valid", 64'(bif.bus_valid), 64'd0);
        chk("rst_owner", 64'(bif.owner), 64'd0);
        chk("rst_bus_addr", bif.bus_addr, 64'd0);
        chk("rst_ready", 64'({bif.if_ready, bif.mem_ready, bif.err}), 64'd0);
        reset = 1'b1;
        tick();

        // Single IF read, acked on first valid cycle, upper word selected by addr[2]
        ack_delay = 0;
        bif.if_req = 1'b1; bif.if_addr = 64'h104;
        wait_ready(1'b1, 10, cyc, vcyc);
        chk("if1_latency", 64'(cyc), 64'd2);
        chk("if1_valid_cycles", 64'(vcyc), 64'd1);
        chk("if1_rdata", 64'(bif.if_rdata), 64'hAAAABBBB);
        chk("if1_owner", 64'(bif.owner), 64'd0);
        bif.if_req = 1'b0;
        tick();

        // Simultaneous IF and MEM write: MEM first, one IDLE cycle, then IF
        ack_delay = 2;
        bif.if_req = 1'b1; bif.if_addr = 64'h200;
        bif.mem_wr = 1'b1; bif.mem_addr = 64'h40; bif.mem_wdata = 64'h1234;
        tick();
        chk("w_owner", 64'(bif.owner), 64'd2);
        chk("w_bus_we", 64'(bif.bus_we), 64'd1);
        chk("w_bus_addr", bif.bus_addr, 64'h40);
        chk("w_bus_wdata", bif.bus_wdata, 64'h1234);
        wait_ready(1'b0, 10, cyc, vcyc);
        bif.mem_wr = 1'b0;
        chk("w_idle_gap", 64'(bif.owner), 64'd0);
        tick();
        chk("w_then_if", 64'(bif.owner), 64'd1);
        chk("w_if_addr", bif.bus_addr, 64'h200);
        wait_ready(1'b1, 10, cyc, vcyc);
        bif.if_req = 1'b0;
        tick();

        // Starvation: continuous MEM reads with IF waiting
        ack_delay = 0;
        bif.mem_rd = 1'b1; bif.mem_addr = 64'h80;
        bif.if_req = 1'b1; bif.if_addr = 64'h0;
        mem_g = 0; if_g = 0; run1 = -1; run2 = -1; prev = 0; stop = 1'b0;
        for (int i = 0; i < 100 && !stop; i++) begin
            tick();
            if (bif.owner == 2'd2 && prev != 2) mem_g++;
            if (bif.owner == 2'd1 && prev != 1) begin
                if_g++;
                if (if_g == 1) begin run1 = mem_g; mem_g = 0; end
                else begin run2 = mem_g; stop = 1'b1; end
            end
            prev = int'(bif.owner);
        end
        chk("starve_run1", 64'(run1), 64'd4);
        chk("starve_run2", 64'(run2), 64'd4);
        chk("starve_mem_rdata", bif.mem_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
        bif.mem_rd = 1'b0; bif.if_req = 1'b0;
        wait_ready(1'b1, 10, cyc, vcyc);
        tick();

        // Timeout on a MEM read
        ack_en = 1'b0;
        bif.mem_rd = 1'b1; bif.mem_addr = 64'h88;
        wait_ready(1'b0, 40, cyc, vcyc);
        chk("to_valid_cycles", 64'(vcyc), 64'd16);
        chk("to_err", 64'(bif.err), 64'd1);
        chk("to_mem_rdata", bif.mem_rdata, 64'd0);
        chk("to_owner", 64'(bif.owner), 64'd0);
        bif.mem_rd = 1'b0;
        tick();
        chk("to_err_pulse", 64'(bif.err), 64'd0);

        // Reset asserted during GNT_IF
        bif.if_req = 1'b1; bif.if_addr = 64'h10;
        tick();
        chk("rg_owner", 64'(bif.owner), 64'd1);
        tick();
        reset = 1'b0;
        #1;
        chk("rg_async_valid", 64'(bif.bus_valid), 64'd0);
        chk("rg_async_owner", 64'(bif.owner), 64'd0);
        bif.if_req = 1'b0;
        ack_en = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        pulses = 0;
        repeat (4) begin
            tick();
            if (bif.if_ready) pulses++;
        end
        chk("rg_no_ready", 64'(pulses), 64'd0);
        chk("rg_owner_idle", 64'(bif.owner), 64'd0);

        // mem_rd and mem_wr together are a write; read data register untouched
        ack_delay = 1;
        bif.mem_rd = 1'b1; bif.mem_wr = 1'b1; bif.mem_addr = 64'h48; bif.mem_wdata = 64'h55;
        tick();
        chk("rw_bus_we", 64'(bif.bus_we), 64'd1);
        chk("rw_bus_wdata", bif.bus_wdata, 64'h55);
        wait_ready(1'b0, 10, cyc, vcyc);
        bif.mem_rd = 1'b0; bif.mem_wr = 1'b0;
        chk("rw_mem_rdata", bif.mem_rdata, 64'd0);
        tick();

        // IF request dropped mid-grant still completes with one ready pulse
        ack_delay = 3;
        bif.bus_rdata = 64'h1111_2222_3333_4444;
        bif.if_req = 1'b1; bif.if_addr = 64'h8;
        tick();
        chk("drop_owner", 64'(bif.owner), 64'd1);
        bif.if_req = 1'b0;
        pulses = 0;
        repeat (8) begin
            tick();
            if (bif.if_ready) pulses++;
        end
        chk("drop_pulses", 64'(pulses), 64'd1);
        chk("drop_if_rdata", 64'(bif.if_rdata), 64'h33334444);

        // Stray bus_ack while IDLE is ignored
        force_ack = 1'b1;
        pulses = 0;
        repeat (2) begin
            tick();
            if (bif.if_ready || bif.mem_ready || bif.err || bif.bus_valid) pulses++;
        end
        force_ack = 1'b0;
        tick();
        chk("idle_ack_ignored", 64'(pulses), 64'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1);
    end
endmodule
